// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-digit BCD stopwatch with prescaler and IDLE/RUN/PAUSE FSM; lap capture under STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] count,
  output logic       running,
  output logic       tick,
  output logic       wrap,
  output logic [7:0] lap_count,
  output logic       lap_valid
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic [7:0] next_count;
  assign running = state == RUN;
  assign tick = running & (presc == LAST) & ~stop & ~clear;
  always_comb
    next_count = count[3:0] == 4'd9 ? {count[7:4] == 4'd9 ? 4'd0 : count[7:4] + 4'd1, 4'd0}
                                    : {count[7:4], count[3:0] + 4'd1};
  // A stop in RUN freezes the prescaler on that edge so a resume loses no phase.
  always_ff @(posedge clk)
    if (reset || clear) begin
      state <= IDLE;
      presc <= '0;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= tick & (count == 8'h99);
      if (tick) begin
        presc <= '0;
        count <= next_count;
      end else if (running && !stop) presc <= presc + PW'(1);
      if (stop) begin
        if (running) state <= PAUSE;
      end else if (start && !running) state <= RUN;
    end
`ifdef STOPWATCH_LAP_EN
  // lap is the lowest-priority command: any stop or start in the same cycle drops it.
  always_ff @(posedge clk)
    if (reset || clear) begin
      lap_count <= '0;
      lap_valid <= 1'b0;
    end else if (lap && !stop && !start && state != IDLE) begin
      lap_count <= count;
      lap_valid <= 1'b1;
    end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_count = 8'h00;
  assign lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl against an integer-count reference model.
module tb_stopwatch_ctrl;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [7:0] count, lap_count;
  logic running, tick, wrap, lap_valid;
  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .count(count), .running(running), .tick(tick), .wrap(wrap),
    .lap_count(lap_count), .lap_valid(lap_valid)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       tick;
    logic [7:0] count;
    logic       running;
    logic       wrap;
    logic [7:0] lap_count;
    logic       lap_valid;
  } obs_t;
  obs_t q[$];
  obs_t exp_o, act_o;
  int vectors = 0, miscompares = 0;
  int mode = 0, n = 0, ph = 0, lap_n = 0;
  bit wrapq = 0, lapv = 0;
  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  task automatic step(input bit r, input bit s, input bit p, input bit c, input bit l);
    obs_t e;
    bit t;
    @(posedge clk);
    #2;
    reset = r; start = s; stop = p; clear = c; lap = l;
    t = (mode == 1) && (ph == DIV - 1) && !p && !c;
    e = '{t, bcd(n), mode == 1, wrapq, lapv ? bcd(lap_n) : 8'h00, lapv};
    q.push_back(e);
    if (r || c) begin
      mode = 0; n = 0; ph = 0; wrapq = 0; lapv = 0; lap_n = 0;
    end else begin
      wrapq = t && n == 99;
`ifdef STOPWATCH_LAP_EN
      if (l && !s && !p && mode != 0) begin
        lap_n = n;
        lapv = 1;
      end
`endif
      if (t) begin
        n = (n + 1) % 100;
        ph = 0;
      end else if (mode == 1 && !p) ph++;
      if (p) begin
        if (mode == 1) mode = 2;
      end else if (s && mode != 1) mode = 1;
    end
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic run_until(input int target, input bit at_last);
    for (int i = 0; i < 2000 && !(n == target && (!at_last || ph == DIV - 1)); i++) step(0, 0, 0, 0, 0);
    if (!(n == target && (!at_last || ph == DIV - 1))) begin
      miscompares++;
      $display("FAIL timeout @%0t: count %0d not reached (at %0d ph %0d)", $time, target, n, ph);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_o = q.pop_front();
      act_o = '{tick, count, running, wrap, lap_count, lap_valid};
      vectors++;
      if (act_o !== exp_o) begin
        miscompares++;
        $display("FAIL vec %0d @%0t: got tick=%b count=%h run=%b wrap=%b lap=%h/%b, want tick=%b count=%h run=%b wrap=%b lap=%h/%b",
                 vectors, $time, act_o.tick, act_o.count, act_o.running, act_o.wrap, act_o.lap_count, act_o.lap_valid,
                 exp_o.tick, exp_o.count, exp_o.running, exp_o.wrap, exp_o.lap_count, exp_o.lap_valid);
      end
    end
  initial begin
    int r;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    if (count !== 8'h00 || running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0 || lap_count !== 8'h00 || lap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state @%0t: count=%h run=%b tick=%b wrap=%b lap=%h/%b",
               $time, count, running, tick, wrap, lap_count, lap_valid);
    end
    step(0, 1, 0, 0, 0);
    idle(8);
    idle(4 * 9);
    idle(4 * 90 + 4);
    idle(3);
    run_until(n, 0);
    for (int i = 0; i < 10 && ph != 2; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(10);
    step(0, 1, 0, 0, 0);
    idle(6);
    run_until(37, 0);
    step(0, 1, 1, 1, 0);
    idle(3);
    step(0, 1, 0, 0, 0);
    run_until(5, 1);
    step(0, 0, 1, 0, 0);
    idle(4);
    step(0, 1, 0, 0, 0);
    run_until(42, 0);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    run_until(23, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 1, 0);
    idle(2);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      step(r < 3, r >= 10 && r < 40, r >= 40 && r < 55, r >= 3 && r < 10, r >= 55 && r < 85);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DIV, default 4, prescaler period in clk cycles per count step (legal range 2..2^24).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle command pulse: begin or resume counting.
REQ-005 Port: stop  input  1  single-cycle command pulse: pause counting.
REQ-006 Port: clear  input  1  single-cycle command pulse: return to idle and zero the count.
REQ-007 Port: lap  input  1  single-cycle command pulse: capture the current count.
REQ-008 Port: count  output  8  two-digit packed BCD count, [7:4] tens, [3:0] units, 00..99.
REQ-009 Port: running  output  1  high while the FSM is in RUN.
REQ-010 Port: tick  output  1  combinational pulse, high in the cycle whose edge increments count.
REQ-011 Port: wrap  output  1  registered pulse, high for the one cycle after count rolls 99->00.
REQ-012 Port: lap_count  output  8  BCD count captured by the last accepted lap.
REQ-013 Port: lap_valid  output  1  high once a lap has been captured since the last clear or reset.

Function
REQ-014 FSM states SHALL be IDLE, RUN and PAUSE; running = (state == RUN).
REQ-015 Command priority in the same cycle SHALL be clear > stop > start > lap.
REQ-016 clear in any state SHALL go to IDLE, zero count, prescaler, wrap, lap_count and lap_valid on that edge.
REQ-017 start in IDLE or PAUSE SHALL enter RUN; start in RUN SHALL be ignored.
REQ-018 stop in RUN SHALL enter PAUSE; stop in IDLE or PAUSE SHALL be ignored.
REQ-019 Prescaler SHALL count 0..DIV-1 only in RUN, hold in PAUSE, and be zero in IDLE.
REQ-020 tick SHALL = (state == RUN) & (prescaler == DIV-1) & ~stop & ~clear; on tick the prescaler SHALL wrap to 0.
REQ-021 On tick, count SHALL increment in BCD: units 9->0 carries into tens; 99->00 sets wrap for the next cycle only.
REQ-022 A stop or clear coincident with prescaler == DIV-1 SHALL suppress the increment; the prescaler holds at DIV-1 in PAUSE.
REQ-023 Latency: start accepted at edge E0 from IDLE SHALL produce count 01 at edge E0+DIV.
REQ-024 Resume from PAUSE SHALL continue from the held prescaler value, with no lost or extra cycles.
REQ-025 count SHALL never hold a non-BCD digit (A..F).

Reset
REQ-026 On reset: state IDLE, count 00, prescaler 0, wrap 0, lap_count 00, lap_valid 0; tick low.
REQ-027 Reset SHALL override all commands in the same cycle, including mid-RUN.

Configuration
REQ-028 Macro STOPWATCH_LAP_EN defined: lap in RUN or PAUSE SHALL capture count (the pre-increment value if tick is coincident) into lap_count and set lap_valid; lap in IDLE SHALL be ignored.
REQ-029 Macro STOPWATCH_LAP_EN undefined: lap SHALL be ignored, lap_count tied to 00, lap_valid tied to 0, and no capture register is synthesized.

Verification (DIV=4)
REQ-030 Reset, then start pulse -> running=1 next cycle, count=01 four edges after start, 02 after eight.
REQ-031 Run to count 09, then one more tick -> count=10; from 99, one more tick -> count=00 and wrap=1 for exactly one cycle.
REQ-032 stop with prescaler==2, wait 10 cycles, then start -> count unchanged while paused; next increment two cycles after resume.
REQ-033 start+stop+clear in one cycle while in RUN at count 37 -> IDLE, count=00, running=0.
REQ-034 stop in the tick cycle at count 05 -> count stays 05 and state is PAUSE; reset mid-RUN at count 42 -> all outputs at reset values.
REQ-035 STOPWATCH_LAP_EN defined: lap at count 23 -> lap_count=23, lap_valid=1; clear -> 00/0. Undefined: lap pulses leave both at 0.
